// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus the UART rx/tx byte streams seen by the memory/IO responder.
interface mem_io_responder_if;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        rdy_out;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        prog_stop;

  modport master (
    output cpu_a, cpu_dout, cpu_wr, rx_data, rx_valid, tx_ready,
    input  cpu_din, rdy_out, rx_ready, tx_data, tx_valid, prog_stop
  );

  modport slave (
    input  cpu_a, cpu_dout, cpu_wr, rx_data, rx_valid, tx_ready,
    output cpu_din, rdy_out, rx_ready, tx_data, tx_valid, prog_stop
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte-bus responder: RAM, rx/tx FIFOs, cycle counter and stop flag at 0x30000; reads land one cycle later.
// rdy_out drops while an rx pop finds no byte or a tx push finds no room; the UART sides are valid/ready.
module byte_fifo #(
  parameter int AW = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  logic [7:0] push_dat,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  logic [7:0]  mem [0:(1<<AW)-1];
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;

  // push/pop arrive already qualified by !full / !empty
  assign wr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_nxt = rd_ptr + {{AW{1'b0}}, pop};
  assign head   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module mem_io_responder #(
  parameter int          RAM_AW   = 17,
  parameter int          FIFO_AW  = 4,
  parameter logic [31:0] CNT_INIT = 32'h0
) (
  input logic               clk_in,
  input logic               rst_in,
  mem_io_responder_if.slave bus
);
  logic [7:0]        ram [0:(1<<RAM_AW)-1];
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        ram_q, io_q, io_rdata, rx_head, tx_head, tx_push_dat;
  logic              ram_sel, rx_rd_prev, prog_stop_q;
  logic [31:0]       cycle_cnt, cnt_snap;
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic              is_io, sel_rx, sel_stop, sel_cnt, rd, wr;
  logic              rx_pop_try, tx_push_try, stall, rd_done;
  logic              unused_hi;

  assign unused_hi = ^bus.cpu_a[31:18];
  assign ram_idx   = bus.cpu_a[RAM_AW-1:0];
  assign rd        = !bus.cpu_wr;
  assign wr        = bus.cpu_wr;
  assign is_io     = (bus.cpu_a[17:16] == 2'b11);
  assign sel_rx    = is_io && (bus.cpu_a[15:0] == 16'h0000);
  assign sel_stop  = is_io && (bus.cpu_a[15:0] == 16'h0004);
  assign sel_cnt   = is_io && (bus.cpu_a[15:2] == 14'h0001);

  // A held rx read address pops only on its first completed cycle
  assign rx_pop_try  = rd && sel_rx && !rx_rd_prev;
  assign tx_push_try = wr && ((sel_rx && bus.cpu_dout != 8'h00) || sel_stop);
  assign stall       = (rx_pop_try && rx_empty) || (tx_push_try && tx_full);
  assign rd_done     = rd && !stall;
  assign tx_push_dat = sel_stop ? 8'h00 : bus.cpu_dout;

  always_comb begin
    io_rdata = 8'h00;
    if (sel_rx) begin
      io_rdata = rx_head;
    end else if (sel_cnt) begin
      unique case (bus.cpu_a[1:0])
        2'd0:    io_rdata = cycle_cnt[7:0];
        2'd1:    io_rdata = cnt_snap[15:8];
        2'd2:    io_rdata = cnt_snap[23:16];
        default: io_rdata = cnt_snap[31:24];
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && wr && !is_io) ram[ram_idx] <= bus.cpu_dout;
    if (!rst_in && rd_done && !is_io) ram_q <= ram[ram_idx];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ram_sel     <= 1'b0;
      io_q        <= 8'h00;
      rx_rd_prev  <= 1'b0;
      prog_stop_q <= 1'b0;
      cycle_cnt   <= CNT_INIT;
      cnt_snap    <= 32'h0;
    end else begin
      cycle_cnt  <= cycle_cnt + 32'd1;
      rx_rd_prev <= rd_done && sel_rx;
      if (rd_done) begin
        if (!is_io) begin
          ram_sel <= 1'b1;
        end else if (!sel_rx || rx_pop_try) begin
          ram_sel <= 1'b0;
          io_q    <= io_rdata;
        end
        if (sel_stop) cnt_snap <= cycle_cnt;
      end
      if (wr && sel_stop && !stall) prog_stop_q <= 1'b1;
    end
  end

  byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (bus.rx_valid && !rx_full),
    .push_dat (bus.rx_data),
    .pop      (rd_done && rx_pop_try),
    .head     (rx_head),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (tx_push_try && !stall),
    .push_dat (tx_push_dat),
    .pop      (!tx_empty && bus.tx_ready),
    .head     (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  assign bus.cpu_din   = ram_sel ? ram_q : io_q;
  assign bus.rdy_out   = !stall;
  assign bus.rx_ready  = !rx_full;
  assign bus.tx_data   = tx_head;
  assign bus.tx_valid  = !tx_empty;
  assign bus.prog_stop = prog_stop_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: vector table, rx/tx/counter sequences, tx scoreboard monitor.
module tb_mem_io_responder;
  logic clk_in = 1'b0;
  logic rst_in;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t        vt [13];
  logic [7:0]  rd_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  tx_exp;
  logic [7:0]  rd_exp;
  logic [31:0] wrap_addr [6];
  logic [7:0]  wrap_exp  [6];

  mem_io_responder_if bus ();
  mem_io_responder_if bus2 ();

  mem_io_responder #(.RAM_AW(17), .FIFO_AW(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  mem_io_responder #(.RAM_AW(17), .FIFO_AW(4), .CNT_INIT(32'hFFFF_FFFE)) u_wrap (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus2)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle;
    bus.cpu_wr   = 1'b1;
    bus.cpu_a    = 32'h0003_0008;
    bus.cpu_dout = 8'h00;
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [7:0] exp, input string name);
    bus.cpu_wr = 1'b0;
    bus.cpu_a  = a;
    #1;
    check({name, "_rdy"}, bus.rdy_out, 1);
    rd_q.push_back(exp);
    tick;
    rd_exp = rd_q.pop_front();
    check({name, "_din"}, bus.cpu_din, rd_exp);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [7:0] d, input string name);
    bus.cpu_wr   = 1'b1;
    bus.cpu_a    = a;
    bus.cpu_dout = d;
    #1;
    check({name, "_rdy"}, bus.rdy_out, 1);
    tick;
  endtask

  // tx scoreboard: every byte the UART takes must be the next one queued by the driver
  always @(negedge clk_in) begin
    if (!rst_in && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      if (tx_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_unexpected: got 0x%0h, want no byte", bus.tx_data);
      end else begin
        tx_exp = tx_q.pop_front();
        check("tx_data", bus.tx_data, tx_exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 32'h0000_0011, 8'h3C, 8'h00};
    vt[1]  = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
    vt[2]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
    vt[3]  = '{1'b0, 32'h0000_0011, 8'h00, 8'h3C};
    vt[4]  = '{1'b1, 32'h0001_0010, 8'h77, 8'h00};
    vt[5]  = '{1'b0, 32'h0001_0010, 8'h00, 8'h77};
    vt[6]  = '{1'b0, 32'h0002_0010, 8'h00, 8'hA5};
    vt[7]  = '{1'b0, 32'hFFFC_0010, 8'h00, 8'hA5};
    vt[8]  = '{1'b0, 32'h0003_1234, 8'h00, 8'h00};
    vt[9]  = '{1'b1, 32'h0003_0008, 8'h55, 8'h00};
    vt[10] = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
    vt[11] = '{1'b0, 32'h0003_0002, 8'h00, 8'h00};
    vt[12] = '{1'b1, 32'h0003_0000, 8'h00, 8'h00};
    wrap_addr = '{32'h30004, 32'h30005, 32'h30006, 32'h30007, 32'h30004, 32'h30005};
    wrap_exp  = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00};

    rst_in = 1'b1;
    idle;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.tx_ready  = 1'b0;
    bus2.cpu_wr   = 1'b1;
    bus2.cpu_a    = 32'h0003_0008;
    bus2.cpu_dout = 8'h00;
    bus2.rx_valid = 1'b0;
    bus2.rx_data  = 8'h00;
    bus2.tx_ready = 1'b0;
    repeat (3) tick;
    rst_in = 1'b0;

    check("rst_cpu_din", bus.cpu_din, 0);
    check("rst_rdy", bus.rdy_out, 1);
    check("rst_rx_ready", bus.rx_ready, 1);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_prog_stop", bus.prog_stop, 0);

    // Counter starting two below wrap: snapshot bytes must not tear as the live count wraps
    for (int i = 0; i < 6; i++) begin
      bus2.cpu_wr = 1'b0;
      bus2.cpu_a  = wrap_addr[i];
      tick;
      check($sformatf("wrap%0d", i), bus2.cpu_din, wrap_exp[i]);
    end
    bus2.cpu_wr = 1'b1;
    bus2.cpu_a  = 32'h0003_0008;

    repeat (32'h1234 - 6) tick;
    cpu_read(32'h30004, 8'h34, "cnt_b0");
    cpu_read(32'h30005, 8'h12, "cnt_b1");
    cpu_read(32'h30006, 8'h00, "cnt_b2");
    cpu_read(32'h30007, 8'h00, "cnt_b3");
    cpu_read(32'h30004, 8'h38, "cnt_again");

    for (int i = 0; i < 13; i++) begin
      if (vt[i].wr) cpu_write(vt[i].a, vt[i].d, $sformatf("vec%0d", i));
      else          cpu_read(vt[i].a, vt[i].exp_din, $sformatf("vec%0d", i));
    end
    idle;
    check("ignored_writes_tx", bus.tx_valid, 0);

    // rx ordering with an idle cycle between reads
    bus.rx_valid = 1'b1; bus.rx_data = 8'h41; tick;
    bus.rx_data = 8'h42; tick;
    bus.rx_valid = 1'b0;
    cpu_read(32'h30000, 8'h41, "rx_first");
    idle; tick;
    cpu_read(32'h30000, 8'h42, "rx_second");
    idle; tick;

    // holding the rx address pops once
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rx_data = 8'h61 + 8'(i);
      tick;
    end
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) cpu_read(32'h30000, 8'h61, $sformatf("rx_hold%0d", i));
    idle; tick;
    cpu_read(32'h30000, 8'h62, "rx_after_hold");
    idle; tick;
    cpu_read(32'h30000, 8'h63, "rx_last");
    idle; tick;

    // stall on empty rx, released the cycle after a push
    bus.cpu_wr = 1'b0; bus.cpu_a = 32'h30000;
    #1;
    check("rx_stall", bus.rdy_out, 0);
    tick;
    check("rx_stall_hold", bus.rdy_out, 0);
    check("rx_stall_din", bus.cpu_din, 8'h63);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    #1;
    check("rx_stall_same_cycle", bus.rdy_out, 0);
    tick;
    bus.rx_valid = 1'b0;
    #1;
    check("rx_release", bus.rdy_out, 1);
    tick;
    check("rx_release_din", bus.cpu_din, 8'h5A);
    idle; tick;

    // fill rx across the index wrap; a push while full is refused even with a same-cycle pop
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.rx_data = 8'h80 + 8'(i);
      tick;
    end
    check("rx_full", bus.rx_ready, 0);
    bus.rx_data = 8'hEE;
    bus.cpu_wr = 1'b0; bus.cpu_a = 32'h30000;
    #1;
    check("rx_full_pop_ready", bus.rx_ready, 0);
    tick;
    bus.rx_valid = 1'b0;
    check("rx_full_pop_din", bus.cpu_din, 8'h80);
    for (int i = 1; i < 16; i++) begin
      idle; tick;
      cpu_read(32'h30000, 8'h80 + 8'(i), $sformatf("rx_drain%0d", i));
    end
    idle; tick;
    bus.cpu_wr = 1'b0; bus.cpu_a = 32'h30000;
    #1;
    check("rx_dropped_byte", bus.rdy_out, 0);
    idle; tick;

    // tx fill, stall on the 17th byte, drain in order
    for (int i = 0; i < 16; i++) begin
      cpu_write(32'h30000, 8'hB0 + 8'(i), $sformatf("tx_fill%0d", i));
      tx_q.push_back(8'hB0 + 8'(i));
    end
    check("tx_valid_full", bus.tx_valid, 1);
    check("tx_head", bus.tx_data, 8'hB0);
    bus.cpu_wr = 1'b1; bus.cpu_a = 32'h30000; bus.cpu_dout = 8'hC0;
    #1;
    check("tx_stall", bus.rdy_out, 0);
    tick;
    check("tx_stall_hold", bus.rdy_out, 0);
    bus.tx_ready = 1'b1;
    #1;
    check("tx_stall_same_cycle", bus.rdy_out, 0);
    tick;
    check("tx_release", bus.rdy_out, 1);
    tx_q.push_back(8'hC0);
    tick;
    idle;
    for (int k = 0; k < 64 && bus.tx_valid; k++) tick;
    check("tx_drained", bus.tx_valid, 0);
    check("tx_q_empty", tx_q.size(), 0);

    // stop flag, then reset mid-operation
    cpu_write(32'h00020, 8'hD7, "ram_keep_wr");
    tx_q.push_back(8'h00);
    cpu_write(32'h30004, 8'h99, "stop_wr");
    idle;
    check("prog_stop_set", bus.prog_stop, 1);
    repeat (4) tick;
    check("stop_tx_emitted", tx_q.size(), 0);
    bus.tx_ready = 1'b0;
    cpu_write(32'h30000, 8'h11, "pre_rst_tx");
    bus.rx_valid = 1'b1; bus.rx_data = 8'h22;
    idle; tick;
    bus.rx_valid = 1'b0;
    check("pre_rst_tx_valid", bus.tx_valid, 1);
    rst_in = 1'b1;
    repeat (2) tick;
    rst_in = 1'b0;
    check("mid_rst_prog_stop", bus.prog_stop, 0);
    check("mid_rst_tx_valid", bus.tx_valid, 0);
    check("mid_rst_rx_ready", bus.rx_ready, 1);
    check("mid_rst_cpu_din", bus.cpu_din, 0);
    check("mid_rst_rdy", bus.rdy_out, 1);
    cpu_read(32'h00020, 8'hD7, "ram_kept");
    bus.tx_ready = 1'b1;
    bus.cpu_wr = 1'b0; bus.cpu_a = 32'h30000;
    #1;
    check("rx_flushed", bus.rdy_out, 0);
    idle;
    repeat (3) tick;
    check("tx_flushed", bus.tx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
